// File: rtl/demux2_buf.sv
// rtl/demux2_buf.sv - two-way buffered byte demultiplexer with a 2-entry FIFO per channel
// in_sel=1 steers to channel 1, in_sel=0 to channel 2; each channel stalls independently.

module demux2_buf_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             push;
   logic             pop;

   // No pass-through when full: a pop in the same cycle does not free the slot early.
   assign in_ready  = (count != FULL);
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd_ptr];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

module demux2_buf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic [1:0]       out1_count,
   output logic             out2_valid,
   input  logic             out2_ready,
   output logic [WIDTH-1:0] out2_data,
   output logic [1:0]       out2_count
);

   logic ch1_ready;
   logic ch2_ready;

   // in_sel -> in_ready is the only combinational input-to-output path.
   assign in_ready = in_sel ? ch1_ready : ch2_ready;

   demux2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid && in_sel),
      .in_ready  (ch1_ready),
      .in_data   (in_data),
      .out_valid (out1_valid),
      .out_ready (out1_ready),
      .out_data  (out1_data),
      .count     (out1_count)
   );

   demux2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid && !in_sel),
      .in_ready  (ch2_ready),
      .in_data   (in_data),
      .out_valid (out2_valid),
      .out_ready (out2_ready),
      .out_data  (out2_data),
      .count     (out2_count)
   );

endmodule

// File: tb/tb_demux2_buf.sv
// tb/tb_demux2_buf.sv - scoreboard bench for demux2_buf with queue-based reference model
module tb_demux2_buf;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       in_sel = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       out1_valid, out2_valid;
   logic       out1_ready = 1'b0, out2_ready = 1'b0;
   logic [7:0] out1_data, out2_data;
   logic [1:0] out1_count, out2_count;

   int n_checks = 0;
   int n_fail = 0;
   logic in_reset = 1'b1;
   logic [7:0] q1[$];
   logic [7:0] q2[$];

   demux2_buf dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
      .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data), .out1_count(out1_count),
      .out2_valid(out2_valid), .out2_ready(out2_ready), .out2_data(out2_data), .out2_count(out2_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: model counts are queue sizes; data is the queue head.
   always @(negedge clk) begin
      if (rst_n && !in_reset) begin
         chk("count1", 32'(out1_count), 32'(q1.size()));
         chk("count2", 32'(out2_count), 32'(q2.size()));
         chk("valid1", 32'(out1_valid), 32'(q1.size() != 0));
         chk("valid2", 32'(out2_valid), 32'(q2.size() != 0));
         chk("in_ready", 32'(in_ready), 32'(in_sel ? (q1.size() < 2) : (q2.size() < 2)));
         if (q1.size() != 0) begin
            chk("data1", 32'(out1_data), 32'(q1[0]));
            if (out1_ready) void'(q1.pop_front());
         end
         if (q2.size() != 0) begin
            chk("data2", 32'(out2_data), 32'(q2[0]));
            if (out2_ready) void'(q2.pop_front());
         end
      end
   end

   // One clock of stimulus; the expected byte is queued when the model accepts it.
   task automatic cycle(input logic v, input logic s, input logic [7:0] d,
                        input logic r1, input logic r2, output logic acc);
      @(posedge clk);
      #1;
      in_valid = v; in_sel = s; in_data = d;
      out1_ready = r1; out2_ready = r2;
      acc = v && (s ? (q1.size() < 2) : (q2.size() < 2));
      @(negedge clk);
      #1;
      if (acc) begin
         if (s) q1.push_back(d);
         else   q2.push_back(d);
      end
   endtask

   task automatic push_wait(input logic s, input logic [7:0] d, input logic r1,
                            input logic r2, input logic rnd);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 30 && !acc; i++) begin
         if (rnd) cycle(1'b1, s, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
         else     cycle(1'b1, s, d, r1, r2, acc);
      end
      if (!acc) begin
         n_checks++; n_fail++;
         $display("FAIL push_timeout: got no accept expected accept of 0x%0h", d);
      end
   endtask

   task automatic idle(input int n, input logic r1, input logic r2);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, r1, r2, acc);
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < 40 && (q1.size() != 0 || q2.size() != 0); i++)
         cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
      idle(1, 1'b1, 1'b1);
      chk("drain_q1", 32'(q1.size()), 32'd0);
      chk("drain_q2", 32'(q2.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic acc;
      #12;
      chk("rst_valid1", 32'(out1_valid), 32'd0);
      chk("rst_valid2", 32'(out2_valid), 32'd0);
      chk("rst_count1", 32'(out1_count), 32'd0);
      chk("rst_count2", 32'(out2_count), 32'd0);
      chk("rst_data1", 32'(out1_data), 32'd0);
      chk("rst_data2", 32'(out2_data), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      in_sel = 1'b1; #1 chk("rst_ready_sel1", 32'(in_ready), 32'd1);
      in_sel = 1'b0; #1 chk("rst_ready_sel0", 32'(in_ready), 32'd1);
      in_reset = 1'b0;

      // Steering
      cycle(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, acc);
      cycle(1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, acc);
      chk("steer_out1", 32'(out1_data), 32'hA5);
      idle(1, 1'b1, 1'b1);
      chk("steer_out2", 32'(out2_data), 32'h3C);
      chk("steer_v1_once", 32'(out1_valid), 32'd0);
      drain();

      // Full / backpressure
      push_wait(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
      push_wait(1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 8'h03, 1'b0, 1'b1, acc);
      chk("bp_accept", 32'(acc), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_count", 32'(out1_count), 32'd2);
      push_wait(1'b1, 8'h03, 1'b1, 1'b1, 1'b0);
      drain();

      // Independence
      push_wait(1'b0, 8'hC1, 1'b1, 1'b0, 1'b0);
      push_wait(1'b0, 8'hC2, 1'b1, 1'b0, 1'b0);
      push_wait(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
      push_wait(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
      idle(3, 1'b1, 1'b0);
      chk("indep_q1_done", 32'(q1.size()), 32'd0);
      chk("indep_count2", 32'(out2_count), 32'd2);
      drain();

      // Simultaneous push and pop at count 1
      push_wait(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 8'h66, 1'b1, 1'b1, acc);
      chk("pp_accept", 32'(acc), 32'd1);
      idle(1, 1'b0, 1'b1);
      chk("pp_count", 32'(out1_count), 32'd1);
      chk("pp_data", 32'(out1_data), 32'h66);
      drain();

      // Pointer wrap: odd bytes to channel 1, even to channel 2
      for (int i = 0; i < 16; i++) push_wait(1'(i), 8'(i), 1'b0, 1'b0, 1'b1);
      drain();

      // Random traffic
      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      drain();

      // Reset mid-operation with both FIFOs full
      push_wait(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
      push_wait(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0);
      push_wait(1'b0, 8'hF1, 1'b0, 1'b0, 1'b0);
      push_wait(1'b0, 8'hF2, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0, 1'b0);
      chk("pre_rst_count1", 32'(out1_count), 32'd2);
      chk("pre_rst_count2", 32'(out2_count), 32'd2);
      @(posedge clk);
      #3;
      in_reset = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid1", 32'(out1_valid), 32'd0);
      chk("mid_rst_valid2", 32'(out2_valid), 32'd0);
      chk("mid_rst_count1", 32'(out1_count), 32'd0);
      chk("mid_rst_count2", 32'(out2_count), 32'd0);
      chk("mid_rst_data1", 32'(out1_data), 32'd0);
      chk("mid_rst_data2", 32'(out2_data), 32'd0);
      q1.delete();
      q2.delete();
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      in_sel = 1'b1; #1 chk("post_rst_ready1", 32'(in_ready), 32'd1);
      in_sel = 1'b0; #1 chk("post_rst_ready0", 32'(in_ready), 32'd1);
      in_reset = 1'b0;
      push_wait(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/demux2_buf.md
# demux2_buf

Two-way buffered demultiplexer for 8-bit data. Steers each accepted input byte to output channel 1 or channel 2 according to a per-transfer select bit. Each channel has its own 2-entry FIFO, so one stalled consumer never blocks traffic to the other. It is the splitting counterpart of the datapath's 2:1 byte muxes, with valid/ready handshaking on every port. Select polarity matches the muxes: sel=1 selects channel 1, sel=0 selects channel 2.

## Interface
- WIDTH, 8, data width of input and both outputs
- DEPTH, 2, entries per channel FIFO; fixed at 2, other values unsupported
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer offers a transfer
- in_ready  output  1  the FIFO addressed by in_sel can accept
- in_sel  input  1  destination: 1 = channel 1, 0 = channel 2; qualified by in_valid
- in_data  input  WIDTH  payload
- out1_valid  output  1  channel 1 FIFO non-empty
- out1_ready  input  1  channel 1 consumer accepts
- out1_data  output  WIDTH  channel 1 head entry
- out1_count  output  2  channel 1 occupancy, 0..2
- out2_valid, out2_ready, out2_data, out2_count  same as channel 1, for channel 2

## Operation
- Push:
  - A push occurs on a clk edge when in_valid && in_ready.
  - in_data is written to the FIFO selected by in_sel at that edge.
- in_ready:
  - in_ready = (in_sel ? out1_count : out2_count) != 2.
  - It is combinational from in_sel and the registered counts.
  - It does not depend on in_valid or on any out*_ready. There is no pass-through when full: a push to a full FIFO is refused even if that FIFO pops in the same cycle.
- Pop: channel k pops on a clk edge when outk_valid && outk_ready. The head advances and the count decrements.
- Per-channel storage:
  - Two WIDTH-bit registers, 1-bit write pointer, 1-bit read pointer, 2-bit count.
  - Pointers wrap 1→0.
- Derived outputs:
  - outk_valid = (outk_count != 0).
  - outk_data = mem[rd_ptr]. It is registered storage, so there is no combinational path from in_data.
- Simultaneous push and pop on the same channel:
  - count 1: count stays 1. The popped entry leaves, and the pushed entry becomes head after the edge.
  - count 2: no push (in_ready=0); the pop proceeds and count becomes 1.
  - count 0: no pop (valid=0); the push proceeds and count becomes 1.
- A push to one channel and a pop from the other in the same cycle are fully independent.
- Ordering: strict FIFO within each channel. There is no ordering relation between channels.
- in_sel may change every cycle. Back-to-back pushes alternate freely between channels.
- Reset (asynchronous assert, synchronous-to-clk deassert by upstream):
  - All counts, pointers and storage go to 0, so out*_valid=0 and out*_data=0.
  - in_ready=1 while rst_n is high after reset.
  - Reset mid-operation discards all buffered data immediately; no pop is reported.
- When outk_valid=0, outk_data holds the stale slot contents and is don't-care (it is 0 only directly after reset).

## Timing
- Latency: a byte pushed at edge N is visible on outk_data with outk_valid=1 after edge N (cycle N+1) when its FIFO was empty.
- Throughput: one push per cycle on the input. Each channel sustains one pop per cycle.
- A channel at count 1 with out_ready held high accepts a push every cycle with no bubble.
- Count update: count_next = count + push − pop, evaluated at the same edge.
- The sole combinational input-to-output path is in_sel → in_ready. Producers must tolerate in_ready depending on in_sel.
- Outputs change only on clk edges or on rst_n assertion.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 mid-cycle with both FIFOs holding 2 entries.
  - Required response: all valids and counts go to 0 immediately and both data outputs read 0x00; after release, in_ready=1 for both sel values.
- Steering:
  - Stimulus: push 0xA5 with sel=1, then 0x3C with sel=0, with both consumers ready.
  - Required response: out1 shows 0xA5 in cycle 2; out2 shows 0x3C in cycle 3; each valid lasts one cycle.
- Full/backpressure:
  - Stimulus: hold out1_ready=0 and push 0x01, 0x02, 0x03 with sel=1.
  - Required response: the third push waits with in_ready=0 and out1_count=2; raising out1_ready yields 0x01, 0x02, 0x03 in order.
- Independence:
  - Stimulus: fill channel 2 (out2_ready=0), then push 0x10 and 0x11 with sel=1.
  - Required response: both channel 1 bytes are accepted and delivered while channel 2 stays at count 2.
- Simultaneous push and pop at count 1:
  - Stimulus: out1 holds 0x55 with out1_ready=1, and 0x66 is pushed to channel 1 in the same cycle.
  - Required response: next cycle out1_count=1 and out1_data=0x66.
- Pointer wrap:
  - Stimulus: stream 0x00..0x0F alternating sel every cycle, with random ready on both channels.
  - Required response: channel 1 receives the odd values and channel 2 the even values, in order, with no loss or duplication.
